// File: rtl/max_pool_ctrl_pkg.sv
// Shared definitions for the max-pooling sequencer: FSM encoding, default
// geometry with its derived constants, and small sizing helpers.
package max_pool_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Default geometry and the constants derived from it.
  localparam int DEF_DEPTH = 8;
  localparam int DEF_X     = 3;
  localparam int DEF_Y     = 3;
  localparam int DEF_IMG_W = 9;
  localparam int DEF_IMG_H = 9;
  localparam int OUT_W     = DEF_IMG_W / DEF_X;
  localparam int OUT_H     = DEF_IMG_H / DEF_Y;
  localparam int WIN       = DEF_X * DEF_Y;

  // Counter width for a count of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of whole windows along one axis; partial windows are dropped.
  function automatic int out_dim(input int img, input int win);
    return img / win;
  endfunction

endpackage

// File: rtl/max_pool_ctrl_max.sv
// Combinational window-max selector: unsigned maximum over X*Y packed pixels.
module max_pool_ctrl_max
  #(parameter int DEPTH = 8,
    parameter int X     = 3,
    parameter int Y     = 3)
  (input  logic [X*Y*DEPTH-1:0] i_win,
   output logic [DEPTH-1:0]     o_max);

  // Linear scan; starting from zero is safe because pixels are unsigned.
  always_comb begin
    o_max = '0;
    for (int k = 0; k < X*Y; k++) begin
      if (i_win[k*DEPTH +: DEPTH] > o_max) o_max = i_win[k*DEPTH +: DEPTH];
    end
  end

endmodule

// File: rtl/max_pool_ctrl.sv
// Non-overlapping X x Y max-pooling sequencer. Reads each window pixel by
// pixel from a 1-cycle-latency input buffer, packs it, reduces it through
// the shared Max unit and writes one result per window.
// Handshake: start is sampled only in IDLE; busy is high from the cycle
// after acceptance until done; done is a single-cycle pulse.
module max_pool_ctrl
  import max_pool_ctrl_pkg::*;
  #(parameter int DEPTH  = 8,
    parameter int X      = 3,
    parameter int Y      = 3,
    parameter int IMG_W  = 9,
    parameter int IMG_H  = 9,
    parameter int ADDR_W = 16)
  (input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DEPTH-1:0]  rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DEPTH-1:0]  wr_data,
   output state_t            o_dbg_state);

  localparam int C_OUT_W = out_dim(IMG_W, X);
  localparam int C_OUT_H = out_dim(IMG_H, Y);
  localparam int C_WIN   = X * Y;
  localparam bit C_EMPTY = (C_OUT_W == 0) || (C_OUT_H == 0);

  localparam int IW  = cnt_w(X);
  localparam int JW  = cnt_w(Y);
  localparam int OXW = cnt_w(C_OUT_W);
  localparam int OYW = cnt_w(C_OUT_H);
  localparam int KW  = cnt_w(C_WIN);

  localparam logic [IW-1:0]  I_LAST  = IW'(X - 1);
  localparam logic [JW-1:0]  J_LAST  = JW'(Y - 1);
  localparam logic [OXW-1:0] OX_LAST = OXW'(C_OUT_W - 1);
  localparam logic [OYW-1:0] OY_LAST = OYW'(C_OUT_H - 1);

  state_t                 r_state;
  logic [IW-1:0]          r_i;
  logic [JW-1:0]          r_j;
  logic [OXW-1:0]         r_ox;
  logic [OYW-1:0]         r_oy;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_rd_en;
  logic [ADDR_W-1:0]      r_rd_addr;
  logic                   r_wr_en;
  logic [ADDR_W-1:0]      r_wr_addr;
  logic                   r_cap_vld;
  logic [KW-1:0]          r_cap_k;
  logic [C_WIN*DEPTH-1:0] r_win;

  logic                   w_i_last;
  logic                   w_j_last;
  logic                   w_ox_last;
  logic                   w_oy_last;
  logic [IW-1:0]          w_i_nxt;
  logic [JW-1:0]          w_j_nxt;
  logic [OXW-1:0]         w_ox_nxt;
  logic [OYW-1:0]         w_oy_nxt;
  logic [DEPTH-1:0]       w_max;

  // Row-major input address of pixel (i,j) inside window (ox,oy).
  function automatic logic [ADDR_W-1:0] pix_addr(input int ox, input int oy,
                                                 input int i, input int j);
    return ADDR_W'((oy*Y + j)*IMG_W + ox*X + i);
  endfunction

  // Next-position logic: i is the inner (column) index, j the outer (row).
  always_comb begin
    w_i_last  = (r_i == I_LAST);
    w_j_last  = (r_j == J_LAST);
    w_ox_last = (r_ox == OX_LAST);
    w_oy_last = (r_oy == OY_LAST);
    w_i_nxt   = w_i_last ? '0 : r_i + 1'b1;
    w_j_nxt   = w_i_last ? r_j + 1'b1 : r_j;
    w_ox_nxt  = w_ox_last ? '0 : r_ox + 1'b1;
    w_oy_nxt  = w_ox_last ? r_oy + 1'b1 : r_oy;
  end

  // Sequencer FSM with registered strobes and addresses.
  // An empty output map takes IDLE -> DRAIN -> DONE so done lands 2 cycles
  // after start with no reads or writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            r_i    <= '0;
            r_j    <= '0;
            r_ox   <= '0;
            r_oy   <= '0;
            if (C_EMPTY) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state   <= ST_FETCH;
              r_rd_en   <= 1'b1;
              r_rd_addr <= '0;
            end
          end
        end
        ST_FETCH: begin
          if (w_i_last && w_j_last) begin
            r_rd_en <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_i       <= w_i_nxt;
            r_j       <= w_j_nxt;
            r_rd_addr <= pix_addr(int'(r_ox), int'(r_oy), int'(w_i_nxt), int'(w_j_nxt));
          end
        end
        ST_DRAIN: begin
          if (C_EMPTY) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state   <= ST_WRITE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= ADDR_W'(int'(r_oy)*C_OUT_W + int'(r_ox));
          end
        end
        ST_WRITE: begin
          r_wr_en <= 1'b0;
          if (w_ox_last && w_oy_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state   <= ST_FETCH;
            r_ox      <= w_ox_nxt;
            r_oy      <= w_oy_nxt;
            r_i       <= '0;
            r_j       <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= pix_addr(int'(w_ox_nxt), int'(w_oy_nxt), 0, 0);
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Window packing: each returned pixel lands in slot j*X+i one cycle after
  // its read strobe, so the last slot fills during DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_vld <= 1'b0;
      r_cap_k   <= '0;
      r_win     <= '0;
    end else begin
      r_cap_vld <= r_rd_en;
      r_cap_k   <= KW'(int'(r_j)*X + int'(r_i));
      if (r_cap_vld) r_win[int'(r_cap_k)*DEPTH +: DEPTH] <= rd_data;
    end
  end

  max_pool_ctrl_max #(.DEPTH(DEPTH), .X(X), .Y(Y)) Max (
    .i_win (r_win),
    .o_max (w_max)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign rd_en       = r_rd_en;
  assign rd_addr     = r_rd_addr;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  // Driven only by the packed window register through Max; the register is
  // complete throughout WRITE.
  assign wr_data     = w_max;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Bench for max_pool_ctrl: four geometries side by side (4x4, 5x5, 1x1 with
// 2x2 windows, and 10x7 with 3x2 windows), each with its own input buffer.
module tb_max_pool_ctrl;
  import max_pool_ctrl_pkg::*;

  localparam int NI = 4;
  localparam int MW = 128;
  localparam int CX[NI] = '{2, 2, 2, 3};
  localparam int CY[NI] = '{2, 2, 2, 2};
  localparam int CW[NI] = '{4, 5, 1, 10};
  localparam int CH[NI] = '{4, 5, 1, 7};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_s  [NI];
  logic        start_s  [NI];
  logic        busy_s   [NI];
  logic        done_s   [NI];
  logic        rd_en_s  [NI];
  logic [15:0] rd_addr_s[NI];
  logic [7:0]  rd_data_s[NI];
  logic        wr_en_s  [NI];
  logic [15:0] wr_addr_s[NI];
  logic [7:0]  wr_data_s[NI];
  state_t      dbg_s    [NI];
  logic [7:0]  mem      [NI][MW];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GX = (g == 3) ? 3 : 2;
    localparam int GY = 2;
    localparam int GW = (g == 0) ? 4 : (g == 1) ? 5 : (g == 2) ? 1 : 10;
    localparam int GH = (g == 0) ? 4 : (g == 1) ? 5 : (g == 2) ? 1 : 7;
    max_pool_ctrl #(.DEPTH(8), .X(GX), .Y(GY), .IMG_W(GW), .IMG_H(GH), .ADDR_W(16)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n_s[g]),
      .start       (start_s[g]),
      .busy        (busy_s[g]),
      .done        (done_s[g]),
      .rd_en       (rd_en_s[g]),
      .rd_addr     (rd_addr_s[g]),
      .rd_data     (rd_data_s[g]),
      .wr_en       (wr_en_s[g]),
      .wr_addr     (wr_addr_s[g]),
      .wr_data     (wr_data_s[g]),
      .o_dbg_state (dbg_s[g])
    );
  end

  // Synchronous-read input buffers, one cycle of latency.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++)
      if (rd_en_s[g]) rd_data_s[g] <= mem[g][rd_addr_s[g][6:0]];
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] exp_rd_q[$];
  logic [23:0] exp_wr_q[$];

  // Expected read order and window results straight from the pooling rules.
  task automatic build_model(input int k);
    int ow, oh, a;
    logic [7:0] m;
    exp_rd_q.delete();
    exp_wr_q.delete();
    ow = CW[k] / CX[k];
    oh = CH[k] / CY[k];
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        m = 8'h00;
        for (int j = 0; j < CY[k]; j++)
          for (int i = 0; i < CX[k]; i++) begin
            a = (oy*CY[k] + j)*CW[k] + ox*CX[k] + i;
            exp_rd_q.push_back(16'(a));
            if (mem[k][a] > m) m = mem[k][a];
          end
        exp_wr_q.push_back({16'(oy*ow + ox), m});
      end
  endtask

  task automatic fill_random(input int k, input int hi);
    for (int a = 0; a < MW; a++) mem[k][a] = 8'($urandom_range(0, hi));
  endtask

  // ---------------- driver ----------------
  // Runs one pass on instance k. mid_start: cycle to re-pulse start;
  // rst_at: cycle to assert reset and abort; hold: keep start high through
  // DONE and check the automatic restart.
  task automatic run_pass(input int k, input int mid_start, input int rst_at, input bit hold);
    int c, first_wr, done_c, nw, nr, ow, oh, win, got_done;
    logic [23:0] e;
    build_model(k);
    ow  = CW[k] / CX[k];
    oh  = CH[k] / CY[k];
    win = CX[k] * CY[k];
    @(negedge clk);
    start_s[k] = 1'b1;
    c = 0; first_wr = -1; done_c = -1; nw = 0; nr = 0;
    while (done_c < 0 && c < 2000) begin
      @(negedge clk);
      c++;
      if (!hold) start_s[k] = (c == mid_start);
      if (c == 1) chk("busy_after_start", busy_s[k], 1);
      if (rd_en_s[k]) begin
        nr++;
        if (exp_rd_q.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", rd_addr_s[k], exp_rd_q.pop_front());
      end
      if (wr_en_s[k]) begin
        nw++;
        if (first_wr < 0) first_wr = c;
        if (exp_wr_q.size() == 0) chk("wr_extra", 1, 0);
        else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", wr_addr_s[k], e[23:8]);
          chk("wr_data", wr_data_s[k], e[7:0]);
        end
      end
      if (c == rst_at) begin
        rst_n_s[k] = 1'b0;
        #1;
        chk("rst_mid_outs", {busy_s[k], done_s[k], rd_en_s[k], wr_en_s[k],
                             rd_addr_s[k], wr_addr_s[k], wr_data_s[k]}, 0);
        chk("rst_mid_state", dbg_s[k], ST_IDLE);
        @(negedge clk);
        chk("rst_mid_no_wr", wr_en_s[k], 0);
        rst_n_s[k] = 1'b1;
        start_s[k] = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle_wr", wr_en_s[k], 0);
        return;
      end
      if (done_s[k]) done_c = c;
    end
    chk("done_cycle", done_c, (ow == 0 || oh == 0) ? 2 : ow*oh*(win + 2) + 1);
    chk("first_wr_cycle", first_wr, (ow == 0 || oh == 0) ? -1 : win + 2);
    chk("rd_count", nr, ow*oh*win);
    chk("wr_count", nw, ow*oh);
    @(negedge clk);
    chk("done_one_cycle", done_s[k], 0);
    if (hold) begin
      chk("hold_idle_no_rd", rd_en_s[k], 0);
      @(negedge clk);
      chk("hold_restart_rd", rd_en_s[k], 1);
      chk("hold_restart_addr", rd_addr_s[k], 0);
      chk("hold_restart_busy", busy_s[k], 1);
      start_s[k] = 1'b0;
      got_done = 0;
      for (int t = 0; t < 2000 && got_done == 0; t++) begin
        @(negedge clk);
        if (done_s[k]) got_done = 1;
      end
      chk("hold_second_done", got_done, 1);
      @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n_s[k] = 1'b0;
      start_s[k] = 1'b0;
      for (int a = 0; a < MW; a++) mem[k][a] = 8'(a);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset_outs", {busy_s[k], done_s[k], rd_en_s[k], wr_en_s[k],
                         rd_addr_s[k], wr_addr_s[k], wr_data_s[k]}, 0);
      chk("reset_state", dbg_s[k], ST_IDLE);
    end
    for (int k = 0; k < NI; k++) rst_n_s[k] = 1'b1;
    repeat (2) @(negedge clk);

    // Basic pass: pixel = address on 4x4 with 2x2 windows.
    run_pass(0, 0, 0, 1'b0);

    // Extremes: window 0 = {00,FF,80,FF}, window 1 all zero.
    fill_random(0, 255);
    mem[0][0] = 8'h00; mem[0][1] = 8'hFF; mem[0][4] = 8'h80; mem[0][5] = 8'hFF;
    mem[0][2] = 8'h00; mem[0][3] = 8'h00; mem[0][6] = 8'h00; mem[0][7] = 8'h00;
    run_pass(0, 0, 0, 1'b0);

    // Start pulsed again mid-pass must be ignored.
    fill_random(0, 255);
    run_pass(0, 9, 0, 1'b0);

    // Reset during the second window's FETCH, then a clean rerun.
    fill_random(0, 255);
    run_pass(0, 0, 8, 1'b0);
    run_pass(0, 0, 0, 1'b0);

    // Start held through DONE restarts on the following IDLE cycle.
    fill_random(0, 3);
    run_pass(0, 0, 0, 1'b1);

    // Edge drop: 5x5 map, trailing column and row never read.
    fill_random(1, 255);
    run_pass(1, 0, 0, 1'b0);

    // Degenerate 1x1 map: no traffic, done two cycles after start.
    run_pass(2, 0, 0, 1'b0);

    // Randomised passes on the non-square 3x2 window geometry.
    for (int t = 0; t < 3; t++) begin
      fill_random(3, (t == 0) ? 7 : 255);
      run_pass(3, 0, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
